// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit for the EXE stage.
// One radix-2 step per cycle: shift-add multiply or restoring divide on operand
// magnitudes, with the result sign applied once at the end. Holds the pipeline via
// mtype_stall_o until the single DONE cycle, where result_o is presented.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            mtype_stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] mag_q, mag_d;   // multiplicand |A| or divisor |B|
  logic [XLEN-1:0] acc_q, acc_d;   // product high half or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier/product low half or dividend/quotient
  logic [XLEN-1:0] res_q, res_d;

  // Issue-time decode of the incoming op
  logic            is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_res;
  logic            issue_neg;

  // Operand signedness, magnitudes and the divide corner cases
  always_comb begin
    is_div   = op_i[2];
    a_signed = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_signed = is_div ? ~op_i[0] : ~op_i[1];
    sa       = a_signed & rs1_i[XLEN-1];
    sb       = b_signed & rs2_i[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1), the correct magnitude
    a_mag    = sa ? -rs1_i : rs1_i;
    b_mag    = sb ? -rs2_i : rs2_i;
    div_zero = is_div & (rs2_i == '0);
    div_ovf  = is_div & ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    special  = div_zero | div_ovf;
    // op_i[1] separates REM* from DIV*
    if (div_zero) begin
      spec_res = op_i[1] ? rs1_i : '1;
    end else begin
      spec_res = op_i[1] ? '0 : rs1_i;
    end
    // Remainder follows the dividend's sign; everything else is sign(A) xor sign(B)
    issue_neg = (is_div & op_i[1]) ? sa : (sa ^ sb);
  end

  // One iteration step for each algorithm, plus the signed final result
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc, mul_lo;
  logic [XLEN:0]     div_shift, div_trial;
  logic [XLEN-1:0]   div_acc, div_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_sel, fin_res;

  // Datapath step and result formatting
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    mul_acc   = mul_sum[XLEN:1];
    mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, mag_q};
    // A borrow out of the trial subtraction means the divisor did not fit: restore
    div_acc   = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], ~div_trial[XLEN]};
    prod      = {mul_acc, mul_lo};
    prod_s    = neg_q ? -prod : prod;
    div_sel   = op_q[1] ? div_acc : div_lo;
    if (op_q[2]) begin
      fin_res = neg_q ? -div_sel : div_sel;
    end else if (op_q[1:0] == 2'b00) begin
      fin_res = prod_s[XLEN-1:0];
    end else begin
      fin_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    res_d   = res_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            op_d  = op_i;
            neg_d = issue_neg;
            mag_d = is_div ? b_mag : a_mag;
            lo_d  = is_div ? a_mag : b_mag;
            acc_d = '0;
            cnt_d = '0;
            if (special) begin
              res_d   = spec_res;
              state_d = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_acc : mul_acc;
          lo_d  = op_q[2] ? div_lo : mul_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CntLast) begin
            res_d   = fin_res;
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  // Pipeline-facing outputs; stall is gated by reset so it drops the moment reset asserts
  always_comb begin
    mtype_stall_o  = rst_n & valid_i & ~flush_i & (state_q != StDone);
    result_valid_o = (state_q == StDone) & ~flush_i;
    result_o       = result_valid_o ? res_q : '0;
  end

endmodule
